// File: rtl/toll_transaction_ctrl.sv
// Toll / recharge transaction controller: reads a vehicle balance from the
// balance RAM, charges or credits it, writes it back and drives the gate.
module toll_transaction_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned GATE_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_id,
    input  logic [DATA_WIDTH-1:0] req_amount,
    input  logic                  req_recharge,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  approved,
    output logic                  denied,
    output logic                  saturated,
    output logic [DATA_WIDTH-1:0] balance_out,
    output logic                  gate_open
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_GATE,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] amount_q;
    logic                  recharge_q;
    logic [CNT_W-1:0]      gate_cnt;

    logic                  accept_c;
    logic [DATA_WIDTH:0]   sum_c;
    logic                  toll_ok_c;
    logic                  ok_c;
    logic [DATA_WIDTH-1:0] new_bal_c;

    // Balance arithmetic evaluated while mem_rdata is valid in CHECK
    always_comb begin
        accept_c  = req_valid && req_ready;
        sum_c     = {1'b0, mem_rdata} + {1'b0, amount_q};
        toll_ok_c = (mem_rdata >= amount_q);
        ok_c      = recharge_q || toll_ok_c;
        new_bal_c = mem_rdata - amount_q;
        if (recharge_q) begin
            new_bal_c = sum_c[DATA_WIDTH] ? '1 : sum_c[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept_c) state_next = S_READ;
            S_READ:  state_next = S_CHECK;
            S_CHECK: state_next = ok_c ? S_WRITE : S_DONE;
            S_WRITE: state_next = recharge_q ? S_DONE : S_GATE;
            S_GATE:  if (gate_cnt <= CNT_W'(1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Registered outputs, latched request and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            mem_we      <= 1'b0;
            gate_open   <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            amount_q    <= '0;
            recharge_q  <= 1'b0;
            approved    <= 1'b0;
            denied      <= 1'b0;
            saturated   <= 1'b0;
            balance_out <= '0;
            gate_cnt    <= '0;
        end else begin
            req_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
            mem_we    <= (state_next == S_WRITE);
            gate_open <= (state_next == S_GATE);
            done      <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        mem_addr   <= req_id;
                        amount_q   <= req_amount;
                        recharge_q <= req_recharge;
                        approved   <= 1'b0;
                        denied     <= 1'b0;
                        saturated  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    approved    <= ok_c;
                    denied      <= !ok_c;
                    saturated   <= recharge_q && sum_c[DATA_WIDTH];
                    balance_out <= ok_c ? new_bal_c : mem_rdata;
                    mem_wdata   <= new_bal_c;
                end
                S_WRITE: gate_cnt <= CNT_W'(GATE_HOLD);
                S_GATE:  gate_cnt <= gate_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_toll_transaction_ctrl.sv
// Bench for toll_transaction_ctrl: directed vector table, queued-request and
// reset corner sequences, then random transactions against a balance model.
module tb_toll_transaction_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int GH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_id = '0;
    logic [DW-1:0] req_amount = '0;
    logic          req_recharge = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, done, approved, denied, saturated, gate_open;
    logic [DW-1:0] balance_out;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;
    int ref_mem [16];

    toll_transaction_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GATE_HOLD(GH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_amount(req_amount), .req_recharge(req_recharge),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .approved(approved), .denied(denied),
        .saturated(saturated), .balance_out(balance_out), .gate_open(gate_open)
    );

    always #5 clk = ~clk;

    // Balance RAM with registered read; bench preload port takes priority
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (pl_en)       mem[pl_addr]  <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int a, input int d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = DW'(d);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Returns the cycle (acceptance edge = 0) in which done is seen, 0 on timeout
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_txn(input int id, input int amt, input int rech,
                           output int app, output int den, output int sat, output int bal,
                           output int lat, output int gates, output int wes, output int rbad);
        wait_ready();
        req_id = AW'(id); req_amount = DW'(amt); req_recharge = rech[0];
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; gates = 0; wes = 0; rbad = 0;
        for (int c = 1; c <= 60; c++) begin
            if (gate_open) gates++;
            if (mem_we) wes++;
            if (req_ready || !busy) rbad++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        app = int'(approved); den = int'(denied); sat = int'(saturated); bal = int'(balance_out);
    endtask

    task automatic check_txn(input string tag, input int id, input int amt, input int rech,
                             input int e_app, input int e_den, input int e_sat,
                             input int e_bal, input int e_lat);
        int app, den, sat, bal, lat, gates, wes, rbad;
        run_txn(id, amt, rech, app, den, sat, bal, lat, gates, wes, rbad);
        chk($sformatf("%s.approved", tag), app, e_app);
        chk($sformatf("%s.denied", tag), den, e_den);
        chk($sformatf("%s.saturated", tag), sat, e_sat);
        chk($sformatf("%s.balance_out", tag), bal, e_bal);
        chk($sformatf("%s.done_cycle", tag), lat, e_lat);
        chk($sformatf("%s.gate_cycles", tag), gates, (e_app != 0 && rech == 0) ? GH : 0);
        chk($sformatf("%s.write_pulses", tag), wes, e_app);
        chk($sformatf("%s.ready_while_busy", tag), rbad, 0);
        chk($sformatf("%s.ram_value", tag), int'(mem[id]), e_bal);
    endtask

    // Outcome of one transaction on a given stored balance, from the rules
    function automatic void model(input int bal, input int amt, input int rech,
                                  output int e_app, output int e_den, output int e_sat,
                                  output int e_bal, output int e_lat);
        int maxv = (1 << DW) - 1;
        e_app = 0; e_den = 0; e_sat = 0; e_bal = bal; e_lat = 3;
        if (rech != 0) begin
            e_app = 1;
            e_sat = (bal + amt > maxv) ? 1 : 0;
            e_bal = e_sat != 0 ? maxv : bal + amt;
            e_lat = 4;
        end else if (bal >= amt) begin
            e_app = 1;
            e_bal = bal - amt;
            e_lat = 4 + GH;
        end else begin
            e_den = 1;
        end
    endfunction

    typedef struct {
        int id; int pre; int init; int amt; int rech;
        int app; int den; int sat; int bal; int lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat, rb, g;
        int e_app, e_den, e_sat, e_bal, e_lat;
        int id, amt, rech;

        //           id pre init amt rech app den sat bal lat
        vecs[0]  = '{ 2, 1, 200,  50, 0,  1,  0,  0, 150, 8};
        vecs[1]  = '{ 2, 0,   0,   0, 0,  1,  0,  0, 150, 8};
        vecs[2]  = '{ 1, 1,  40,  50, 0,  0,  1,  0,  40, 3};
        vecs[3]  = '{ 4, 1,  50,  50, 0,  1,  0,  0,   0, 8};
        vecs[4]  = '{ 4, 0,   0,   1, 0,  0,  1,  0,   0, 3};
        vecs[5]  = '{ 5, 1, 120, 200, 1,  1,  0,  1, 255, 4};
        vecs[6]  = '{ 3, 1,  75,  25, 1,  1,  0,  0, 100, 4};
        vecs[7]  = '{ 6, 1, 255,   0, 1,  1,  0,  0, 255, 4};
        vecs[8]  = '{ 7, 1,   0,   0, 0,  1,  0,  0,   0, 8};
        vecs[9]  = '{ 8, 1, 254,   1, 1,  1,  0,  0, 255, 4};
        vecs[10] = '{ 9, 1, 255,   1, 1,  1,  0,  1, 255, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", int'(req_ready), 1);
        chk("rst.busy", int'(busy), 0);
        chk("rst.mem_we", int'(mem_we), 0);
        chk("rst.gate_open", int'(gate_open), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.flags", int'({approved, denied, saturated}), 0);
        chk("rst.balance_out", int'(balance_out), 0);
        chk("rst.mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].pre != 0) preload(vecs[i].id, vecs[i].init);
            check_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].amt, vecs[i].rech,
                      vecs[i].app, vecs[i].den, vecs[i].sat, vecs[i].bal, vecs[i].lat);
        end

        // Two queued requests with req_valid held high
        preload(11, 90);
        preload(12, 10);
        wait_ready();
        req_id = 4'd11; req_amount = 8'd20; req_recharge = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_id = 4'd12; req_amount = 8'd5; req_recharge = 1'b1;
        rb = 0; lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (req_ready) rb++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("queue.ready_low", rb, 0);
        chk("queue.first_done_cycle", lat, 4 + GH);
        chk("queue.first_balance", int'(balance_out), 70);
        @(posedge clk); #1;
        chk("queue.idle_ready", int'(req_ready), 1);
        chk("queue.flags_held", int'(approved), 1);
        chk("queue.balance_held", int'(balance_out), 70);
        chk("queue.addr_held", int'(mem_addr), 11);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("queue.second_busy", int'(busy), 1);
        chk("queue.flags_cleared", int'(approved), 0);
        wait_done(lat);
        chk("queue.second_done_cycle", lat, 4);
        chk("queue.second_balance", int'(balance_out), 15);
        chk("queue.second_sat", int'(saturated), 0);
        chk("queue.ram11", int'(mem[11]), 70);

        // Reset asserted during WRITE aborts the write
        preload(10, 100);
        wait_ready();
        req_id = 4'd10; req_amount = 8'd30; req_recharge = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        while (!mem_we && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("wrst.reached_write", int'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("wrst.mem_we", int'(mem_we), 0);
        chk("wrst.req_ready", int'(req_ready), 1);
        chk("wrst.busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("wrst.ram_unchanged", int'(mem[10]), 100);

        // Reset asserted mid-GATE closes the gate at once
        preload(13, 60);
        wait_ready();
        req_id = 4'd13; req_amount = 8'd10; req_recharge = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        while (!gate_open && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        chk("grst.gate_was_open", int'(gate_open), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("grst.gate_open", int'(gate_open), 0);
        chk("grst.req_ready", int'(req_ready), 1);
        chk("grst.busy", int'(busy), 0);
        chk("grst.approved", int'(approved), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("grst.ram_written", int'(mem[13]), 50);
        check_txn("grst.after", 13, 50, 0, 1, 0, 0, 0, 4 + GH);

        // Random transactions against the balance model
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = int'($urandom_range(0, 255));
            preload(i, ref_mem[i]);
        end
        for (int i = 0; i < 40; i++) begin
            id   = int'($urandom_range(0, 15));
            rech = ($urandom_range(0, 2) == 0) ? 1 : 0;
            amt  = ($urandom_range(0, 3) == 0) ? ref_mem[id] : int'($urandom_range(0, 255));
            model(ref_mem[id], amt, rech, e_app, e_den, e_sat, e_bal, e_lat);
            check_txn($sformatf("rnd%0d", i), id, amt, rech, e_app, e_den, e_sat, e_bal, e_lat);
            ref_mem[id] = e_bal;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
